// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - boot-time byte-stream loader that writes words into instruction memory
module instruction_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [15:0] words_loaded,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CHECK  = 3'd5,
      S_DONE   = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

   state_t      state;
   state_t      state_next;
   logic [15:0] count;
   logic [1:0]  byte_idx;
   logic [7:0]  checksum;
   logic [31:0] word_reg;
   logic        xfer;
   logic [15:0] count_full;
   logic [16:0] words_next;

   assign xfer       = byte_valid && byte_ready;
   // The low header byte is still on the bus when the length is judged.
   assign count_full = {count[15:8], byte_in};
   assign words_next = {1'b0, words_loaded} + 17'd1;
   // The shift register doubles as the write-data holding register.
   assign mem_wdata  = word_reg;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode from handshake, header length and checksum.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (xfer) state_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (xfer) begin
               if ({1'b0, count_full} > MAX_COUNT) state_next = S_ERROR;
               else if (count_full == 16'd0)       state_next = S_CHECK;
               else                                state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer && byte_idx == 2'd3) state_next = S_WRITE;
         end
         S_WRITE: begin
            if (words_next < {1'b0, count}) state_next = S_DATA;
            else                            state_next = S_CHECK;
         end
         S_CHECK: begin
            if (xfer) state_next = (byte_in == checksum) ? S_DONE : S_ERROR;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_hold   = 1'b1;
      case (state)
         S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: byte_ready = 1'b1;
         S_WRITE: mem_we = 1'b1;
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
         S_ERROR: error = 1'b1;
         default: ;
      endcase
   end

   // Datapath: header capture, word assembly, checksum and address/count stepping.
   always_ff @(posedge clk) begin
      if (reset) begin
         count        <= 16'd0;
         byte_idx     <= 2'd0;
         checksum     <= 8'd0;
         word_reg     <= 32'd0;
         mem_addr     <= BASE_ADDR;
         words_loaded <= 16'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  count        <= 16'd0;
                  byte_idx     <= 2'd0;
                  checksum     <= 8'd0;
                  mem_addr     <= BASE_ADDR;
                  words_loaded <= 16'd0;
               end
            end
            S_LEN_HI: begin
               if (xfer) count[15:8] <= byte_in;
            end
            S_LEN_LO: begin
               if (xfer) begin
                  count[7:0] <= byte_in;
                  byte_idx   <= 2'd0;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  word_reg <= {word_reg[23:0], byte_in};
                  checksum <= checksum ^ byte_in;
                  byte_idx <= byte_idx + 2'd1;
               end
            end
            S_WRITE: begin
               mem_addr     <= mem_addr + 32'd4;
               words_loaded <= words_loaded + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - randomized self-checking bench for instruction_loader
module tb_instruction_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          MAXW = 4;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [15:0] words_loaded;
   logic        cpu_hold;
   logic        done;
   logic        error;

   instruction_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .words_loaded(words_loaded), .cpu_hold(cpu_hold),
      .done(done), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the byte stream of a load and what it must produce.
   logic [7:0]  stream_q[$];
   logic [31:0] wbuf[0:15];
   logic [31:0] exp_addr[0:15];
   logic [31:0] exp_data[0:15];
   int          exp_n;
   logic        exp_done;
   logic [7:0]  model_chk;

   // Observed by the monitor.
   int          acc_cnt;
   int          nwrites;
   logic        prev_xfer;
   logic [31:0] got_addr[0:15];
   logic [31:0] got_data[0:15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Builds the stream for a load of cnt words from wbuf; corrupt is XORed into the checksum byte.
   task automatic build(input logic [15:0] cnt, input logic [7:0] corrupt);
      logic [7:0] c;
      stream_q = {};
      stream_q.push_back(cnt[15:8]);
      stream_q.push_back(cnt[7:0]);
      exp_n = 0;
      if (int'(cnt) > MAXW) begin
         exp_done  = 1'b0;
         model_chk = 8'h00;
      end else begin
         c = 8'h00;
         for (int i = 0; i < int'(cnt); i++) begin
            for (int b = 3; b >= 0; b--) begin
               stream_q.push_back(wbuf[i][b*8 +: 8]);
               c = c ^ wbuf[i][b*8 +: 8];
            end
            exp_addr[i] = BASE + 32'(4 * i);
            exp_data[i] = wbuf[i];
         end
         stream_q.push_back(c ^ corrupt);
         exp_n     = int'(cnt);
         exp_done  = (corrupt == 8'h00);
         model_chk = c;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offers the first lim bytes of stream_q with random valid gaps and junk on idle cycles.
   task automatic stream(input int pct, input int lim);
      int idx = 0;
      int guard = 0;
      while (idx < lim) begin
         byte_valid = ($urandom_range(99) < pct);
         byte_in    = byte_valid ? stream_q[idx] : 8'($urandom);
         @(negedge clk);
         if (byte_valid && byte_ready) idx++;
         @(posedge clk); #1;
         guard++;
         if (guard > 3000) begin
            chk("stream_timeout", 32'(idx), 32'(lim));
            break;
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic run_load(input logic [15:0] cnt, input logic [7:0] corrupt, input int pct);
      build(cnt, corrupt);
      do_start();
      stream(pct, stream_q.size());
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("done",         32'(done),         32'(exp_done));
      chk("error",        32'(error),        32'(!exp_done));
      chk("cpu_hold",     32'(cpu_hold),     32'(!exp_done));
      chk("words_loaded", 32'(words_loaded), 32'(exp_n));
      chk("write_count",  32'(nwrites),      32'(exp_n));
      chk("ready_idle",   32'(byte_ready),   32'd0);
      @(posedge clk); #1;
   endtask

   // Checks every write pulse against the model and against the accepted-byte count.
   always @(negedge clk) begin
      if (reset || start) begin
         acc_cnt   <= 0;
         nwrites   <= 0;
         prev_xfer <= 1'b0;
      end else begin
         if (mem_we) begin
            chk("ready_in_write", 32'(byte_ready), 32'd0);
            if (nwrites >= exp_n) begin
               chk("unexpected_write", 32'(nwrites), 32'(exp_n));
            end else begin
               chk("mem_addr",   mem_addr,  exp_addr[nwrites]);
               chk("mem_wdata",  mem_wdata, exp_data[nwrites]);
               chk("write_lat",  32'(prev_xfer && acc_cnt == 2 + 4 * (nwrites + 1)), 32'd1);
               got_addr[nwrites] <= mem_addr;
               got_data[nwrites] <= mem_wdata;
            end
            nwrites <= nwrites + 1;
         end
         prev_xfer <= byte_valid && byte_ready;
         if (byte_valid && byte_ready) acc_cnt <= acc_cnt + 1;
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      exp_n = 0; exp_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_byte_ready",   32'(byte_ready),   32'd0);
      chk("rst_mem_we",       32'(mem_we),       32'd0);
      chk("rst_mem_addr",     mem_addr,          BASE);
      chk("rst_mem_wdata",    mem_wdata,         32'd0);
      chk("rst_words_loaded", 32'(words_loaded), 32'd0);
      chk("rst_done",         32'(done),         32'd0);
      chk("rst_error",        32'(error),        32'd0);
      chk("rst_cpu_hold",     32'(cpu_hold),     32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Nominal two-word load.
      wbuf[0] = 32'h3C08_1234; wbuf[1] = 32'h0000_0008;
      run_load(16'd2, 8'h00, 100);
      chk("pin_checksum", 32'(model_chk), 32'h1A);
      chk("pin_data0",    got_data[0],    32'h3C08_1234);
      chk("pin_addr0",    got_addr[0],    32'h0000_0000);
      chk("pin_data1",    got_data[1],    32'h0000_0008);
      chk("pin_addr1",    got_addr[1],    32'h0000_0004);

      // Same stream, checksum 0x1B.
      run_load(16'd2, 8'h01, 70);
      // Oversize header and the largest accepted count.
      run_load(16'd5, 8'h00, 100);
      run_load(16'h0104, 8'h00, 60);
      for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
      run_load(16'd4, 8'h00, 50);
      // Zero-length loads, good and bad checksum.
      run_load(16'd0, 8'h00, 100);
      run_load(16'd0, 8'h01, 80);

      // Reset during byte 2 of word 2.
      wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222; wbuf[2] = 32'h3333_3333;
      build(16'd3, 8'h00);
      do_start();
      stream(60, 7);
      @(negedge clk);
      chk("mid_words_loaded", 32'(words_loaded), 32'd1);
      chk("mid_write_count",  32'(nwrites),      32'd1);
      @(posedge clk); #1;
      reset = 1'b1; byte_valid = 1'b1; byte_in = stream_q[7];
      @(posedge clk); #1;
      reset = 1'b0; byte_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_mem_we",   32'(mem_we),       32'd0);
      chk("rst_mid_addr",     mem_addr,          BASE);
      chk("rst_mid_words",    32'(words_loaded), 32'd0);
      chk("rst_mid_ready",    32'(byte_ready),   32'd0);
      chk("rst_mid_hold",     32'(cpu_hold),     32'd1);
      @(posedge clk); #1;
      run_load(16'd3, 8'h00, 75);

      // Randomized loads with gaps and occasional corruption or oversize headers.
      for (int t = 0; t < 16; t++) begin
         logic [15:0] cnt;
         logic [7:0]  cor;
         for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
         if ($urandom_range(0, 7) == 0) cnt = 16'h0100 | 16'($urandom_range(0, 255));
         else                           cnt = 16'($urandom_range(0, MAXW + 1));
         cor = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         run_load(cnt, cor, $urandom_range(30, 100));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Boot-time writer for the instruction memory.
- Accepts a byte stream over a valid/ready handshake: 16-bit word-count header, big-endian 32-bit instruction words, then a trailing XOR checksum byte.
- Writes each assembled word into instruction memory at consecutive word-aligned byte addresses.
- Holds the CPU (fetch/PC) in reset via cpu_hold until the load finishes. It is the write-side counterpart of the instruction fetch path.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first instruction word written; must be word-aligned.
- MAX_WORDS, 1024, largest accepted word count; larger headers go to ERROR.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE, DONE or ERROR.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  out  32  byte address of the word being written; low 2 bits always 00.
- mem_wdata  out  32  instruction word being written.
- words_loaded  out  16  count of words written in the current load.
- cpu_hold  out  1  holds the CPU in reset while loading.
- done  out  1  load completed, checksum matched.
- error  out  1  load aborted: oversize count or checksum mismatch.

Behaviour:
- Transfer rule: a byte transfers on a rising edge where byte_valid && byte_ready. byte_in is ignored otherwise.
- Reset values: state=IDLE; byte_ready=0; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; words_loaded=0; done=0; error=0; cpu_hold=1.
- Reset mid-load: returns to IDLE immediately and no further writes occur. Words already written stay in memory.
- IDLE: byte_ready=0, cpu_hold=1. start=1 -> LEN_HI. Clears count, checksum, done and error; mem_addr=BASE_ADDR.
- LEN_HI: byte_ready=1. Transfer -> count[15:8]=byte_in -> LEN_LO.
- LEN_LO: byte_ready=1. Transfer -> count[7:0]=byte_in, then evaluate the full 16-bit count:
  - count > MAX_WORDS -> ERROR.
  - count == 0 -> CHECK.
  - otherwise -> DATA with byte index 0.
- DATA: byte_ready=1.
  - Each transfer shifts the byte into the word register MSB-first: first byte -> bits 31:24, fourth byte -> bits 7:0.
  - Each transfer XORs the byte into the 8-bit running checksum.
  - The byte index wraps 3->0; the 4th transfer -> WRITE.
- WRITE, exactly one cycle:
  - byte_ready=0; mem_we=1; mem_wdata = assembled word; mem_addr = current address.
  - Next cycle: mem_addr += 4, words_loaded += 1, mem_we=0.
  - Next state: DATA if words_loaded+1 < count, else CHECK.
- CHECK: byte_ready=1. Transfer -> compare byte_in with the running checksum:
  - equal -> DONE;
  - unequal -> ERROR.
  - For count==0 the expected checksum is 8'h00.
- DONE: done=1, cpu_hold=0, byte_ready=0. start=1 -> new load (as from IDLE); done clears and cpu_hold=1 the next cycle.
- ERROR: error=1, cpu_hold=1, byte_ready=0. start=1 -> new load; error clears.
- start is ignored in LEN_HI, LEN_LO, DATA, WRITE and CHECK.
- Address arithmetic: mem_addr is a 32-bit counter and wraps modulo 2^32 without flagging.
- Throughput: 5 cycles per word minimum (4 transfers + 1 WRITE).
- Latency: the last byte of a word is transferred at edge N; mem_we is high in the cycle after edge N.
- A byte presented while byte_ready=0 is held by the source; the loader never drops it.

Test Plan:
- Nominal: start; stream 00 02, 3C 08 12 34, 00 00 00 08, then checksum 3C^08^12^34^00^00^00^08 = 0x1A.
  -> Write 0x3C081234 @0x00, then write 0x00000008 @0x04.
  -> words_loaded=2, done=1, cpu_hold=0, error=0.
- Bad checksum: same stream with final byte 0x1B -> both writes occur, then error=1, done=0, cpu_hold=1.
- Oversize: MAX_WORDS=4, header 00 05 -> ERROR right after the 2nd byte; no mem_we pulse; byte_ready=0.
- Zero length: header 00 00 then 00 -> DONE, words_loaded=0, no writes. Checksum 01 instead -> ERROR.
- Backpressure/gaps: byte_valid toggled randomly and held during WRITE.
  -> Exactly one mem_we per 4 accepted data bytes; byte_ready=0 during each WRITE cycle; no byte lost or duplicated.
- Reset mid-load: assert reset after word 1 is written, during byte 2 of word 2.
  -> Next cycle IDLE, mem_we=0, mem_addr=BASE_ADDR, words_loaded=0.
  -> A subsequent start plus the full stream completes normally.
